spectrum_frame_buffer: RTL and testbench
========================================

Name: spectrum_frame_buffer

Overview:
- Consumer of the per-channel magnitude write streams produced by the dual-channel FFT controller (data / addr / valid per channel).
- Stores each channel's spectrum in ping-pong RAM banks, so the display/measurement side always reads a complete, coherent frame.
- Tracks the peak bin per frame.
- Bank swaps occur only at a reader-supplied frame boundary, so a displayed frame is never torn.

Parameters:
- FFT_POINTS, 8192, bins per frame (power of two).
- ADDR_WIDTH, 13, bin address width, equal to log2(FFT_POINTS).
- DATA_WIDTH, 16, magnitude width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ch1_wr_data  in  DATA_WIDTH  CH1 magnitude.
- ch1_wr_addr  in  ADDR_WIDTH  CH1 bin index.
- ch1_wr_valid  in  1  CH1 write strobe.
- ch2_wr_data / ch2_wr_addr / ch2_wr_valid  in  as CH1  CH2 write stream.
- rd_frame_start  in  1  reader frame-boundary pulse (e.g. display vsync); swap point.
- rd_en  in  1  read request.
- rd_ch  in  1  read channel select, 0=CH1, 1=CH2.
- rd_addr  in  ADDR_WIDTH  read bin index.
- rd_data  out  DATA_WIDTH  read result.
- rd_valid  out  1  rd_data qualifier.
- ch1_frame_valid / ch2_frame_valid  out  1  channel has at least one published frame.
- ch1_peak_mag / ch2_peak_mag  out  DATA_WIDTH  peak magnitude of the published frame.
- ch1_peak_bin / ch2_peak_bin  out  ADDR_WIDTH  bin of that peak.
- ch1_frame_cnt / ch2_frame_cnt  out  16  published-frame counter, wraps 0xFFFF->0.
- ch1_err / ch2_err  out  1  one-cycle pulse on a sequence error or overrun.

Behaviour:
- Reset:
  - All outputs 0; per-channel state WR_IDLE; wr_bank=0 (read bank = ~wr_bank = 1); expected address 0; peak trackers 0.
  - RAM contents are not cleared.
  - Asserting reset mid-frame abandons the frame; no publication.
- Per-channel write FSM (identical, independent instances), registered state:
  - WR_IDLE:
    - valid && addr==0: write RAM[wr_bank][0], expected=1, peak tracker cleared, go to WR_FILL.
    - valid with addr!=0: dropped, err pulse.
  - WR_FILL:
    - valid && addr==expected: write, expected++.
    - addr==FFT_POINTS-1 accepted: go to WR_DONE.
    - valid && addr==0: restart the frame (as in WR_IDLE), err pulse.
    - Any other addr: frame dropped, err pulse, go to WR_IDLE.
    - No timeout; gaps between valids are allowed.
  - WR_DONE: all writes are dropped. A write with addr==0 additionally pulses err (overrun). State holds until swap.
- Swap:
  - Condition: rd_frame_start high and registered channel state == WR_DONE.
  - Effect on the next edge: wr_bank toggles; state goes to WR_IDLE; peak_mag/peak_bin load from the tracker; frame_cnt++; frame_valid goes to 1 and stays.
  - The two channels swap independently in the same cycle when both are DONE.
  - rd_frame_start coincident with the final write (addr FFT_POINTS-1): no swap this cycle; the swap waits for the next rd_frame_start.
- Peak tracker:
  - Considers accepted writes with 1 <= addr < FFT_POINTS/2 only. DC and the mirrored half are excluded.
  - Replaces on strictly greater magnitude, so ties keep the lowest bin.
  - If no candidate bins qualify, it publishes mag 0, bin 0.
- Read path:
  - Latency 2: rd_en at cycle N gives rd_data/rd_valid at cycle N+2. This is a fully pipelined one-per-cycle synchronous RAM read plus an output register.
  - Bank = ~wr_bank[rd_ch] sampled at cycle N. An rd_en coincident with rd_frame_start reads the pre-swap bank.
  - rd_valid=0 when no request is in flight; rd_data holds its last value.
  - Reads of a channel with frame_valid=0 return undefined data, with rd_valid still asserted.
- Read and write never touch the same bank of a channel, so no collision handling is needed.
- Memory: 2 channels x 2 banks x FFT_POINTS x DATA_WIDTH, inferred simple dual-port block RAM.

Test Plan:
- CH1 writes bins 0..8191 with data = bin mod 4096, then rd_frame_start.
  - ch1_frame_cnt=1, ch1_frame_valid=1.
  - Reading rd_ch=0 at addr 100 returns 100 exactly 2 cycles after rd_en.
  - ch1_peak_bin=4095, mag=4095.
- Frame with bin 0 = 0xFFFF, bins 300 and 700 = 0x4000, all others 0x0010.
  - peak_mag=0x4000, peak_bin=300 (DC excluded, tie keeps the lower bin).
  - Bin 5000 = 0xFFFF does not affect the peak.
- CH2 frame skips bin 10 (jumps 9 to 11): ch2_err pulses once, state returns to WR_IDLE, no publication on rd_frame_start, ch2_frame_cnt stays 0.
- A second full CH1 frame completes before rd_frame_start, then a third frame starts at addr 0.
  - ch1_err pulses.
  - After rd_frame_start, the published data matches the second frame.
- rd_frame_start asserted in the same cycle as the CH1 addr-8191 write: no swap. The next rd_frame_start swaps and the count increments by exactly 1.
- rst_n is asserted mid-fill at bin 4000 and then released; a full frame is written and rd_frame_start given.
  - The published frame is correct and ch1_frame_cnt=1.
  - All outputs read 0 during reset.

Source files
------------

// File: rtl/spectrum_frame_buffer.sv
// Ping-pong spectrum frame buffer for a dual-channel FFT magnitude stream.
// Each channel fills its write bank in strict bin order. The reader always sees
// the other bank, so a displayed frame is never torn. A completed frame is
// published only at a reader frame boundary. At that point the banks swap and
// the frame's peak bin becomes visible.
module spectrum_frame_buffer #(
  parameter int FFT_POINTS = 8192,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] ch1_wr_data,
  input  logic [ADDR_WIDTH-1:0] ch1_wr_addr,
  input  logic                  ch1_wr_valid,
  input  logic [DATA_WIDTH-1:0] ch2_wr_data,
  input  logic [ADDR_WIDTH-1:0] ch2_wr_addr,
  input  logic                  ch2_wr_valid,
  input  logic                  rd_frame_start,
  input  logic                  rd_en,
  input  logic                  rd_ch,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  ch1_frame_valid,
  output logic                  ch2_frame_valid,
  output logic [DATA_WIDTH-1:0] ch1_peak_mag,
  output logic [DATA_WIDTH-1:0] ch2_peak_mag,
  output logic [ADDR_WIDTH-1:0] ch1_peak_bin,
  output logic [ADDR_WIDTH-1:0] ch2_peak_bin,
  output logic [15:0]           ch1_frame_cnt,
  output logic [15:0]           ch2_frame_cnt,
  output logic                  ch1_err,
  output logic                  ch2_err
);

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_FILL = 2'd1,
    WR_DONE = 2'd2
  } wr_state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(FFT_POINTS - 1);

  // Both write streams are packed so the per-channel logic can be generated.
  logic [1:0]                 wr_valid_v;
  logic [1:0][ADDR_WIDTH-1:0] wr_addr_v;
  logic [1:0][DATA_WIDTH-1:0] wr_data_v;

  assign wr_valid_v = {ch2_wr_valid, ch1_wr_valid};
  assign wr_addr_v  = {ch2_wr_addr,  ch1_wr_addr};
  assign wr_data_v  = {ch2_wr_data,  ch1_wr_data};

  for (genvar c = 0; c < 2; c++) begin : ch_g
    wr_state_t             state;
    wr_state_t             state_nxt;
    logic                  vld;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] exp_addr;
    logic                  wr_bank;
    logic                  wr_acc;
    logic                  frame_open;
    logic                  err_nxt;
    logic                  swap;
    logic                  peak_cand;
    logic [DATA_WIDTH-1:0] trk_mag;
    logic [ADDR_WIDTH-1:0] trk_bin;
    logic [DATA_WIDTH-1:0] peak_mag;
    logic [ADDR_WIDTH-1:0] peak_bin;
    logic [15:0]           frame_cnt;
    logic                  frame_valid;
    logic                  err;
    logic [DATA_WIDTH-1:0] ram_q_p1;
    logic [DATA_WIDTH-1:0] mem [0:2*FFT_POINTS-1];

    assign vld  = wr_valid_v[c];
    assign addr = wr_addr_v[c];
    assign data = wr_data_v[c];

    // Peak candidates are bins 1 .. FFT_POINTS/2-1. DC and the mirrored upper
    // half are excluded, and the upper half is exactly the bins with the MSB set.
    assign peak_cand = (addr != '0) && !addr[ADDR_WIDTH-1];

    // Write FSM state register; reset abandons any frame in progress
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= WR_IDLE;
      else        state <= state_nxt;
    end

    // Write FSM next-state and per-cycle control decode
    always_comb begin
      state_nxt  = state;
      wr_acc     = 1'b0;
      frame_open = 1'b0;
      err_nxt    = 1'b0;
      swap       = 1'b0;
      unique case (state)
        WR_IDLE: begin
          if (vld) begin
            if (addr == '0) begin
              wr_acc     = 1'b1;
              frame_open = 1'b1;
              state_nxt  = WR_FILL;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end
        WR_FILL: begin
          if (vld) begin
            if (addr == exp_addr) begin
              wr_acc = 1'b1;
              if (addr == LAST_BIN) state_nxt = WR_DONE;
            end else if (addr == '0) begin
              // The source restarted mid-frame; begin again from bin 0.
              wr_acc     = 1'b1;
              frame_open = 1'b1;
              err_nxt    = 1'b1;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = WR_IDLE;
            end
          end
        end
        WR_DONE: begin
          // A finished frame waits for the reader. Any new frame start overruns it.
          if (vld && (addr == '0)) err_nxt = 1'b1;
          if (rd_frame_start) begin
            swap      = 1'b1;
            state_nxt = WR_IDLE;
          end
        end
        default: state_nxt = WR_IDLE;
      endcase
    end

    // Frame bookkeeping: expected bin, peak tracker, bank swap and publication
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        exp_addr    <= '0;
        wr_bank     <= 1'b0;
        trk_mag     <= '0;
        trk_bin     <= '0;
        peak_mag    <= '0;
        peak_bin    <= '0;
        frame_cnt   <= '0;
        frame_valid <= 1'b0;
        err         <= 1'b0;
      end else begin
        err <= err_nxt;
        if (frame_open) begin
          exp_addr <= ADDR_WIDTH'(1);
          trk_mag  <= '0;
          trk_bin  <= '0;
        end else if (wr_acc) begin
          exp_addr <= exp_addr + ADDR_WIDTH'(1);
          // Strictly greater keeps the lowest bin on ties.
          if (peak_cand && (data > trk_mag)) begin
            trk_mag <= data;
            trk_bin <= addr;
          end
        end
        if (swap) begin
          wr_bank     <= ~wr_bank;
          peak_mag    <= trk_mag;
          peak_bin    <= trk_bin;
          frame_cnt   <= frame_cnt + 16'd1;
          frame_valid <= 1'b1;
        end
      end
    end

    // RAM write port: accepted bins land in the current write bank
    always_ff @(posedge clk) begin
      if (wr_acc) mem[{wr_bank, addr}] <= data;
    end

    // ---- read stage p1: synchronous RAM read of the published bank ----
    always_ff @(posedge clk) begin
      if (rd_en) ram_q_p1 <= mem[{~wr_bank, rd_addr}];
    end
  end

  logic vld_p1;
  logic vld_p2;
  logic rd_ch_p1;

  // Read qualifier pipeline, one request per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      vld_p2 <= vld_p1;
    end
  end

  // Channel select travels alongside the RAM read
  always_ff @(posedge clk) begin
    rd_ch_p1 <= rd_ch;
  end

  // ---- read stage p2: output register, holds its value between requests ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rd_data <= '0;
    else if (vld_p1) rd_data <= rd_ch_p1 ? ch_g[1].ram_q_p1 : ch_g[0].ram_q_p1;
  end

  assign rd_valid        = vld_p2;
  assign ch1_frame_valid = ch_g[0].frame_valid;
  assign ch2_frame_valid = ch_g[1].frame_valid;
  assign ch1_peak_mag    = ch_g[0].peak_mag;
  assign ch2_peak_mag    = ch_g[1].peak_mag;
  assign ch1_peak_bin    = ch_g[0].peak_bin;
  assign ch2_peak_bin    = ch_g[1].peak_bin;
  assign ch1_frame_cnt   = ch_g[0].frame_cnt;
  assign ch2_frame_cnt   = ch_g[1].frame_cnt;
  assign ch1_err         = ch_g[0].err;
  assign ch2_err         = ch_g[1].err;

endmodule

// File: tb/tb_spectrum_frame_buffer.sv
// Bench for spectrum_frame_buffer: random frames, scoreboarded reads, and a
// frame-level reference model of publication and peak search.
module tb_spectrum_frame_buffer;
  localparam int N  = 8192;
  localparam int AW = 13;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] ch1_wr_data = '0, ch2_wr_data = '0;
  logic [AW-1:0] ch1_wr_addr = '0, ch2_wr_addr = '0;
  logic          ch1_wr_valid = 1'b0, ch2_wr_valid = 1'b0;
  logic          rd_frame_start = 1'b0, rd_en = 1'b0, rd_ch = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          ch1_frame_valid, ch2_frame_valid;
  logic [DW-1:0] ch1_peak_mag, ch2_peak_mag;
  logic [AW-1:0] ch1_peak_bin, ch2_peak_bin;
  logic [15:0]   ch1_frame_cnt, ch2_frame_cnt;
  logic          ch1_err, ch2_err;

  spectrum_frame_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .ch1_wr_data(ch1_wr_data), .ch1_wr_addr(ch1_wr_addr), .ch1_wr_valid(ch1_wr_valid),
    .ch2_wr_data(ch2_wr_data), .ch2_wr_addr(ch2_wr_addr), .ch2_wr_valid(ch2_wr_valid),
    .rd_frame_start(rd_frame_start), .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .ch1_frame_valid(ch1_frame_valid), .ch2_frame_valid(ch2_frame_valid),
    .ch1_peak_mag(ch1_peak_mag), .ch2_peak_mag(ch2_peak_mag),
    .ch1_peak_bin(ch1_peak_bin), .ch2_peak_bin(ch2_peak_bin),
    .ch1_frame_cnt(ch1_frame_cnt), .ch2_frame_cnt(ch2_frame_cnt),
    .ch1_err(ch1_err), .ch2_err(ch2_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Reference model: frame being written, completed-but-unpublished frame, published frame
  logic [DW-1:0] fr  [2][N];
  logic [DW-1:0] pend[2][N];
  logic [DW-1:0] pub [2][N];
  bit  done_m[2];
  bit  fv_m[2];
  int  cnt_m[2];
  int  pk_mag[2];
  int  pk_bin[2];
  int  err_exp[2];
  int  err_seen[2];

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Read monitor: every rd_valid must match the oldest outstanding request, on its due cycle
  always @(negedge clk) begin
    if (rd_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: rd_valid with no request in flight, data 0x%0h", rd_data);
      end else begin
        e = sb.pop_front();
        if (rd_data !== e.d || cyc != e.due) begin
          errors++;
          $display("FAIL rd_data: got 0x%0h at cycle %0d expected 0x%0h at cycle %0d",
                   rd_data, cyc, e.d, e.due);
        end
      end
    end else if (sb.size() > 0 && sb[0].due < cyc) begin
      checks++;
      errors++;
      e = sb.pop_front();
      $display("FAIL rd_missing: no rd_valid by cycle %0d expected 0x%0h", e.due, e.d);
    end
  end

  // Error-pulse counter
  always @(negedge clk) begin
    if (ch1_err) err_seen[0]++;
    if (ch2_err) err_seen[1]++;
  end

  function automatic void calc_peak(input int ch);
    pk_mag[ch] = 0;
    pk_bin[ch] = 0;
    for (int i = 1; i < N / 2; i++)
      if (int'(pub[ch][i]) > pk_mag[ch]) begin
        pk_mag[ch] = int'(pub[ch][i]);
        pk_bin[ch] = i;
      end
  endfunction

  function automatic void mark_complete(input int ch);
    for (int i = 0; i < N; i++) pend[ch][i] = fr[ch][i];
    done_m[ch] = 1'b1;
  endfunction

  function automatic void model_swap();
    for (int ch = 0; ch < 2; ch++)
      if (done_m[ch]) begin
        for (int i = 0; i < N; i++) pub[ch][i] = pend[ch][i];
        cnt_m[ch]  = (cnt_m[ch] + 1) & 16'hFFFF;
        fv_m[ch]   = 1'b1;
        done_m[ch] = 1'b0;
        calc_peak(ch);
      end
  endfunction

  function automatic void model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      done_m[ch] = 1'b0;
      fv_m[ch]   = 1'b0;
      cnt_m[ch]  = 0;
      pk_mag[ch] = 0;
      pk_bin[ch] = 0;
    end
  endfunction

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Write bins lo..hi from fr[] on the enabled channels, with random idle gaps
  task automatic write_bins(input bit en1, input bit en2, input int lo, input int hi,
                            input bit pulse_last);
    for (int a = lo; a <= hi; a++) begin
      if ($urandom_range(15) == 0) begin
        @(negedge clk);
        ch1_wr_valid = 1'b0;
        ch2_wr_valid = 1'b0;
        rd_frame_start = 1'b0;
      end
      @(negedge clk);
      ch1_wr_valid = en1; ch1_wr_addr = AW'(a); ch1_wr_data = fr[0][a];
      ch2_wr_valid = en2; ch2_wr_addr = AW'(a); ch2_wr_data = fr[1][a];
      rd_frame_start = pulse_last && (a == hi);
    end
    @(negedge clk);
    ch1_wr_valid = 1'b0;
    ch2_wr_valid = 1'b0;
    rd_frame_start = 1'b0;
  endtask

  task automatic issue_read(input int ch, input int addr);
    exp_t x;
    @(negedge clk);
    rd_en = 1'b1; rd_ch = ch[0]; rd_addr = AW'(addr);
    x.d = pub[ch][addr];
    x.due = cyc + 2;
    sb.push_back(x);
  endtask

  task automatic end_reads();
    @(negedge clk);
    rd_en = 1'b0;
    for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
  endtask

  task automatic random_reads(input int n, input int max_ch);
    for (int i = 0; i < n; i++) issue_read($urandom_range(max_ch), $urandom_range(N - 1));
    end_reads();
  endtask

  task automatic pulse(input bit with_read, input int rch, input int raddr);
    exp_t x;
    @(negedge clk);
    rd_frame_start = 1'b1;
    if (with_read) begin
      rd_en = 1'b1; rd_ch = rch[0]; rd_addr = AW'(raddr);
      x.d = pub[rch][raddr];
      x.due = cyc + 2;
      sb.push_back(x);
    end
    model_swap();
    @(negedge clk);
    rd_frame_start = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_ch1_cnt"},  ch1_frame_cnt,   cnt_m[0]);
    chk({tag, "_ch2_cnt"},  ch2_frame_cnt,   cnt_m[1]);
    chk({tag, "_ch1_fv"},   ch1_frame_valid, fv_m[0]);
    chk({tag, "_ch2_fv"},   ch2_frame_valid, fv_m[1]);
    chk({tag, "_ch1_pmag"}, ch1_peak_mag,    pk_mag[0]);
    chk({tag, "_ch2_pmag"}, ch2_peak_mag,    pk_mag[1]);
    chk({tag, "_ch1_pbin"}, ch1_peak_bin,    pk_bin[0]);
    chk({tag, "_ch2_pbin"}, ch2_peak_bin,    pk_bin[1]);
    chk({tag, "_ch1_errs"}, err_seen[0],     err_exp[0]);
    chk({tag, "_ch2_errs"}, err_seen[1],     err_exp[1]);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_data"},  rd_data, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_fv"},       {ch1_frame_valid, ch2_frame_valid}, 0);
    chk({tag, "_pmag"},     {ch1_peak_mag, ch2_peak_mag}, 0);
    chk({tag, "_pbin"},     {ch1_peak_bin, ch2_peak_bin}, 0);
    chk({tag, "_cnt"},      {ch1_frame_cnt, ch2_frame_cnt}, 0);
    chk({tag, "_err"},      {ch1_err, ch2_err}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      err_exp[ch]  = 0;
      err_seen[ch] = 0;
    end

    // Power-on reset
    settle(3);
    check_zero("por");
    @(negedge clk);
    rst_n = 1'b1;
    settle(2);
    check_status("idle");

    // CH2 skips bin 10: one error, no publication
    for (int i = 0; i < N; i++) fr[1][i] = DW'(i);
    write_bins(1'b0, 1'b1, 0, 9, 1'b0);
    write_bins(1'b0, 1'b1, 11, 11, 1'b0);
    err_exp[1]++;
    pulse(1'b0, 0, 0);
    settle(3);
    check_status("ch2_skip");

    // Full frames on both channels; CH1 data = bin mod 4096
    for (int i = 0; i < N; i++) begin
      fr[0][i] = DW'(i % 4096);
      fr[1][i] = DW'($urandom);
    end
    write_bins(1'b1, 1'b1, 0, N - 1, 1'b0);
    mark_complete(0);
    mark_complete(1);
    settle(2);
    check_status("done_unpub");
    pulse(1'b0, 0, 0);
    settle(2);
    check_status("frame1");
    chk("frame1_ch1_peak_bin", ch1_peak_bin, 4095);
    chk("frame1_ch1_peak_mag", ch1_peak_mag, 4095);
    chk("frame1_ch1_cnt", ch1_frame_cnt, 1);
    issue_read(0, 100);
    end_reads();
    random_reads(40, 1);

    // Peak rules: DC excluded, tie keeps lower bin, upper half excluded
    for (int i = 0; i < N; i++) fr[0][i] = 16'h0010;
    fr[0][0]    = 16'hFFFF;
    fr[0][300]  = 16'h4000;
    fr[0][700]  = 16'h4000;
    fr[0][5000] = 16'hFFFF;
    write_bins(1'b1, 1'b0, 0, N - 1, 1'b0);
    mark_complete(0);
    pulse(1'b0, 0, 0);
    settle(2);
    check_status("peak");
    chk("peak_mag_4000", ch1_peak_mag, 16'h4000);
    chk("peak_bin_300", ch1_peak_bin, 300);
    issue_read(0, 0);
    issue_read(0, 300);
    issue_read(1, 77);
    issue_read(0, 5000);
    end_reads();

    // Overrun: completed frame followed by a new bin 0 before the swap
    for (int i = 0; i < N; i++) fr[0][i] = DW'($urandom);
    write_bins(1'b1, 1'b0, 0, N - 1, 1'b0);
    mark_complete(0);
    fr[0][0] = DW'($urandom);
    write_bins(1'b1, 1'b0, 0, 0, 1'b0);
    err_exp[0]++;
    settle(3);
    check_status("overrun_pre");
    pulse(1'b0, 0, 0);
    settle(2);
    check_status("overrun_pub");
    random_reads(40, 0);

    // Frame boundary coincident with the last write: swap deferred
    for (int i = 0; i < N; i++) fr[0][i] = DW'($urandom);
    write_bins(1'b1, 1'b0, 0, N - 1, 1'b1);
    mark_complete(0);
    settle(2);
    check_status("coinc_noswap");
    pulse(1'b1, 0, 1234);
    settle(2);
    check_status("coinc_swap");
    chk("coinc_ch1_cnt", ch1_frame_cnt, 4);
    end_reads();
    random_reads(40, 1);

    // Reset mid-fill, then a clean frame
    for (int i = 0; i < N; i++) fr[0][i] = DW'($urandom);
    write_bins(1'b1, 1'b0, 0, 3999, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero("mid_reset");
    settle(2);
    check_zero("mid_reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) fr[0][i] = DW'($urandom);
    write_bins(1'b1, 1'b0, 0, N - 1, 1'b0);
    mark_complete(0);
    pulse(1'b0, 0, 0);
    settle(2);
    check_status("post_reset");
    chk("post_reset_ch1_cnt", ch1_frame_cnt, 1);
    random_reads(40, 0);

    settle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
